// File: rtl/food_spawn_ctrl_if.sv
// Food request/delivery handshake between the players and the shared
// placement controller: level requests in, one-cycle ack plus cell out.
interface food_spawn_ctrl_if #(
    parameter int NUM_LEN = 10
);
    logic [1:0]         req;
    logic [1:0]         ack;
    logic [NUM_LEN-1:0] new_food;

    // Player side drives requests and consumes the delivered cell.
    modport master (
        output req,
        input  ack,
        input  new_food
    );

    // Controller side consumes requests and delivers cells.
    modport slave (
        input  req,
        output ack,
        output new_food
    );
endinterface

// File: rtl/food_spawn_ctrl.sv
// Shared food-placement sequencer. Round-robin arbitration between the two
// players, samples the free-running LFSR, rejects off-board cells and the
// current foods, then walks both snakes one segment per cycle before
// delivering an unoccupied cell with a one-cycle ack.
module food_spawn_ctrl #(
    parameter int MAX_LEN         = 16,
    parameter int NUM_LEN         = 10,
    parameter int MAX_LEN_BIT_LEN = 4,
    parameter int WIDTH           = 32,
    parameter int HEIGHT          = 24,
    parameter int MAX_TRIES       = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    food_spawn_ctrl_if.slave           bus,
    input  logic [NUM_LEN-1:0]         rand_in,
    input  logic [NUM_LEN-1:0]         food1,
    input  logic [NUM_LEN-1:0]         food2,
    output logic [MAX_LEN_BIT_LEN-1:0] seg_idx,
    input  logic [NUM_LEN-1:0]         seg1,
    input  logic [NUM_LEN-1:0]         seg2,
    output logic                       busy,
    output logic                       starved
);

    localparam int TRY_W = $clog2(MAX_TRIES + 1);
    // One extra bit so the board size is representable for any NUM_LEN.
    localparam logic [NUM_LEN:0]         CELLS    = (NUM_LEN + 1)'(WIDTH * HEIGHT);
    localparam logic [TRY_W-1:0]         TRY_MAX  = TRY_W'(MAX_TRIES);
    localparam logic [MAX_LEN_BIT_LEN-1:0] LAST_IDX = MAX_LEN_BIT_LEN'(MAX_LEN - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAMPLE = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t                     state_q,    state_d;
    logic                       gnt_q,      gnt_d;
    logic                       last_gnt_q, last_gnt_d;
    logic [NUM_LEN-1:0]         cand_q,     cand_d;
    logic [MAX_LEN_BIT_LEN-1:0] seg_idx_q,  seg_idx_d;
    logic [TRY_W-1:0]           tries_q,    tries_d;
    logic [1:0]                 ack_q,      ack_d;
    logic [NUM_LEN-1:0]         new_food_q, new_food_d;
    logic                       busy_q,     busy_d;
    logic                       starved_q,  starved_d;

    logic                       sample_bad_s;
    logic                       seg_hit_s;
    logic [TRY_W-1:0]           tries_inc_s;

    // Candidate screening and saturating try counter increment.
    always_comb begin
        sample_bad_s = ({1'b0, rand_in} >= CELLS) || (rand_in == food1) || (rand_in == food2);
        seg_hit_s    = (cand_q == seg1) || (cand_q == seg2);
        if (tries_q < TRY_MAX) begin
            tries_inc_s = tries_q + TRY_W'(1);
        end else begin
            tries_inc_s = tries_q;
        end
    end

    // Next-state and next-output computation for the placement sequencer.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_gnt_d = last_gnt_q;
        cand_d     = cand_q;
        seg_idx_d  = seg_idx_q;
        tries_d    = tries_q;
        ack_d      = 2'b00;
        new_food_d = new_food_q;

        case (state_q)
            IDLE: begin
                if (bus.req != 2'b00) begin
                    if (bus.req == 2'b11) begin
                        gnt_d = ~last_gnt_q;
                    end else begin
                        gnt_d = bus.req[1];
                    end
                    state_d = SAMPLE;
                end else begin
                    state_d = IDLE;
                end
            end
            SAMPLE: begin
                cand_d = rand_in;
                if (sample_bad_s) begin
                    tries_d = tries_inc_s;
                    state_d = SAMPLE;
                end else begin
                    seg_idx_d = '0;
                    state_d   = CHECK;
                end
            end
            CHECK: begin
                if (seg_hit_s) begin
                    // Occupied: draw a fresh sample, scan restarts from index 0.
                    tries_d = tries_inc_s;
                    state_d = SAMPLE;
                end else if (seg_idx_q == LAST_IDX) begin
                    new_food_d = cand_q;
                    state_d    = DONE;
                end else begin
                    seg_idx_d = seg_idx_q + MAX_LEN_BIT_LEN'(1);
                    state_d   = CHECK;
                end
            end
            DONE: begin
                if (gnt_q) begin
                    ack_d = 2'b10;
                end else begin
                    ack_d = 2'b01;
                end
                last_gnt_d = gnt_q;
                tries_d    = '0;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d    = (state_d != IDLE);
        starved_d = (tries_d >= TRY_MAX);
    end

    // State and registered outputs; synchronous reset aborts any job silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_q      <= 1'b0;
            last_gnt_q <= 1'b1;
            cand_q     <= '0;
            seg_idx_q  <= '0;
            tries_q    <= '0;
            ack_q      <= 2'b00;
            new_food_q <= '0;
            busy_q     <= 1'b0;
            starved_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_gnt_q <= last_gnt_d;
            cand_q     <= cand_d;
            seg_idx_q  <= seg_idx_d;
            tries_q    <= tries_d;
            ack_q      <= ack_d;
            new_food_q <= new_food_d;
            busy_q     <= busy_d;
            starved_q  <= starved_d;
        end
    end

    assign bus.ack      = ack_q;
    assign bus.new_food = new_food_q;
    assign seg_idx      = seg_idx_q;
    assign busy         = busy_q;
    assign starved      = starved_q;

endmodule

// File: tb/tb_food_spawn_ctrl.sv
// Directed bench for food_spawn_ctrl: latency, arbitration order, rejects,
// segment hits, starvation and mid-job reset.
module tb_food_spawn_ctrl;

    logic       clk;
    logic       rst;
    logic [9:0] rand_in;
    logic [9:0] food1;
    logic [9:0] food2;
    logic [3:0] seg_idx;
    logic [9:0] seg1;
    logic [9:0] seg2;
    logic       busy;
    logic       starved;
    logic       hit_en;

    int n_vec;
    int n_err;

    logic [9:0] rseq [0:15];
    int         rlen;

    food_spawn_ctrl_if #(.NUM_LEN(10)) bus ();

    food_spawn_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .rand_in (rand_in),
        .food1   (food1),
        .food2   (food2),
        .seg_idx (seg_idx),
        .seg1    (seg1),
        .seg2    (seg2),
        .busy    (busy),
        .starved (starved)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Snake model: all slots off-board, except an optional snake2 body at index 9 = cell 7.
    assign seg1 = 10'd1023;
    assign seg2 = (hit_en && seg_idx == 4'd9) ? 10'd7 : 10'd1023;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Grant edge, then feed rseq one value per SAMPLE edge and time the ack.
    task automatic serve(input logic [1:0] exp_ack, input int exp_lat,
                         input logic [9:0] exp_food, input string tag);
        int cyc;
        rand_in = rseq[0];
        tick();
        cyc = 0;
        while (bus.ack == 2'b00 && cyc < 200) begin
            tick();
            cyc++;
            if (cyc < rlen) rand_in = rseq[cyc];
        end
        check_val({tag, "_ack"},  32'(bus.ack), 32'(exp_ack));
        check_val({tag, "_lat"},  32'(cyc), 32'(exp_lat));
        check_val({tag, "_food"}, 32'(bus.new_food), 32'(exp_food));
        bus.req = bus.req & ~bus.ack;
    endtask

    initial begin
        int cyc;
        n_vec   = 0;
        n_err   = 0;
        rst     = 1'b1;
        bus.req = 2'b00;
        rand_in = 10'd5;
        food1   = 10'd100;
        food2   = 10'd100;
        hit_en  = 1'b0;
        rseq[0] = 10'd5;
        rlen    = 1;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check_val("rst_ack",     32'(bus.ack), 32'd0);
        check_val("rst_food",    32'(bus.new_food), 32'd0);
        check_val("rst_seg_idx", 32'(seg_idx), 32'd0);
        check_val("rst_busy",    32'(busy), 32'd0);
        check_val("rst_starved", 32'(starved), 32'd0);

        // 1: single request, clean first sample
        bus.req = 2'b01;
        serve(2'b01, 18, 10'd5, "t1");
        tick();
        check_val("t1_ack_pulse", 32'(bus.ack), 32'd0);
        check_val("t1_busy_low",  32'(busy), 32'd0);

        // 2: round-robin order between simultaneous requests (fresh reset)
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.req = 2'b11;
        serve(2'b01, 18, 10'd5, "t2a");
        serve(2'b10, 18, 10'd5, "t2b");
        bus.req = 2'b11;
        serve(2'b01, 18, 10'd5, "t2c");
        bus.req = bus.req | 2'b01;
        serve(2'b10, 18, 10'd5, "t2d");
        serve(2'b01, 18, 10'd5, "t2e");
        tick();

        // 3: off-board and food collisions rejected in SAMPLE
        rseq[0] = 10'd800;
        rseq[1] = 10'd100;
        rseq[2] = 10'd7;
        rlen    = 3;
        bus.req = 2'b01;
        serve(2'b01, 20, 10'd7, "t3");
        check_val("t3_starved", 32'(starved), 32'd0);
        tick();

        // 4: snake2 occupies cell 7 at index 9
        hit_en  = 1'b1;
        rseq[0] = 10'd7;
        rseq[1] = 10'd8;
        rlen    = 2;
        bus.req = 2'b10;
        serve(2'b10, 29, 10'd8, "t4");
        hit_en  = 1'b0;
        tick();

        // 5: ten rejects against food2, starvation flag, then delivery of 12
        food2   = 10'd200;
        rand_in = 10'd200;
        bus.req = 2'b01;
        tick();
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 7 || k == 8 || k == 10) begin
                check_val($sformatf("t5_starved_%0d", k), 32'(starved), (k >= 8) ? 32'd1 : 32'd0);
                check_val($sformatf("t5_busy_%0d", k), 32'(busy), 32'd1);
            end
        end
        rand_in = 10'd12;
        cyc = 10;
        while (bus.ack == 2'b00 && cyc < 200) begin
            tick();
            cyc++;
        end
        check_val("t5_ack",     32'(bus.ack), 32'd1);
        check_val("t5_lat",     32'(cyc), 32'd28);
        check_val("t5_food",    32'(bus.new_food), 32'd12);
        check_val("t5_starved", 32'(starved), 32'd0);
        bus.req = 2'b00;
        food2   = 10'd100;
        tick();

        // 6: reset during CHECK index 6, request held, job re-run from scratch
        rseq[0] = 10'd9;
        rlen    = 1;
        rand_in = 10'd9;
        bus.req = 2'b01;
        tick();
        for (int k = 0; k < 7; k++) tick();
        check_val("t6_idx6", 32'(seg_idx), 32'd6);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("t6_ack",     32'(bus.ack), 32'd0);
        check_val("t6_food",    32'(bus.new_food), 32'd0);
        check_val("t6_seg_idx", 32'(seg_idx), 32'd0);
        check_val("t6_busy",    32'(busy), 32'd0);
        serve(2'b01, 18, 10'd9, "t6r");
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
